// File: rtl/wb_bram_slave.sv
// wb_bram_slave: Wishbone classic slave in front of a word-addressed block RAM.
// Independent read/write wait states, byte-lane writes, address-window decode
// with an error response, and abort when the master drops cyc mid-transaction.
module wb_bram_slave #(
    parameter int unsigned DW         = 32,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h3800_0000,
    parameter int unsigned RD_DELAYS  = 10,
    parameter int unsigned WR_DELAYS  = 10,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_we_i,
    input  logic [DW/8-1:0]      wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [DW-1:0]        wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic                 wbs_err_o,
    output logic [DW-1:0]        wbs_dat_o,
    output logic                 busy_o,
    output logic [15:0]          txn_cnt_o
);

    localparam int unsigned SEL_W  = DW / 8;
    localparam int unsigned OFF_W  = $clog2(SEL_W);
    localparam int unsigned IDX_HI = DEPTH_LOG2 + OFF_W;
    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [DW-1:0]         wdat_q, wdat_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [DW-1:0]         rdat_q, rdat_d;
    logic                  busy_q, busy_d;
    logic [15:0]           txn_q, txn_d;

    logic                  valid_c;
    logic                  in_win_c;
    logic [DEPTH_LOG2-1:0] adr_idx_c;
    logic                  mem_we_c;
    logic [DW-1:0]         mem_rd_c;
    logic                  unused_adr_bits;

    logic [DW-1:0]         mem [DEPTH];

    // Request decode: valid strobe, window match and word index.
    assign valid_c         = wbs_cyc_i & wbs_stb_i;
    assign in_win_c        = (wbs_adr_i[31:IDX_HI] == BASE_ADDR[31:IDX_HI]);
    assign adr_idx_c       = wbs_adr_i[IDX_HI-1 -: DEPTH_LOG2];
    assign mem_rd_c        = mem[idx_q];
    // Byte-offset bits below the word index carry no meaning here.
    assign unused_adr_bits = ^wbs_adr_i;

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        wdat_d  = wdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdat_d  = '0;
        txn_d   = txn_q;
        mem_we_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (valid_c) begin
                    if (in_win_c) begin
                        we_d    = wbs_we_i;
                        sel_d   = wbs_sel_i;
                        idx_d   = adr_idx_c;
                        wdat_d  = wbs_dat_i;
                        cnt_d   = wbs_we_i ? CNT_W'(WR_DELAYS) : CNT_W'(RD_DELAYS);
                        state_d = S_WAIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                    if (we_q) begin
                        mem_we_c = 1'b1;
                    end else begin
                        rdat_d = mem_rd_c;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK: begin
                txn_d   = txn_q + 16'd1;
                state_d = S_IDLE;
            end
            S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            idx_q   <= '0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            busy_q  <= 1'b0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
            busy_q  <= busy_d;
            txn_q   <= txn_d;
        end
    end

    // RAM write port with byte-lane enables; contents survive reset.
    always_ff @(posedge wb_clk_i) begin
        for (int unsigned b = 0; b < SEL_W; b++) begin
            if (mem_we_c && sel_q[b]) begin
                mem[idx_q][b*8 +: 8] <= wdat_q[b*8 +: 8];
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;
    assign wbs_dat_o = rdat_q;
    assign busy_o    = busy_q;
    assign txn_cnt_o = txn_q;

endmodule

// File: doc/wb_bram_slave.md
# wb_bram_slave

Parametrised Wishbone classic slave fronting an internal word-addressed block RAM in the user project area, the successor to the fixed 32-bit, single-delay BRAM responder. It adds configurable data width and depth, separate read and write wait-state counts, byte-lane writes, address-window decode with an error response, and cycle-abort handling. The block is driven by the management SoC over the Wishbone bus, and its status outputs are intended for the logic analyzer.

## Interface
- DW, 32, data width in bits; a multiple of 8, minimum 8
- DEPTH_LOG2, 10, log2 of the number of DW-bit words in the RAM
- BASE_ADDR, 32'h3800_0000, byte base address of the RAM window; aligned to the window size
- RD_DELAYS, 10, extra wait cycles before a read is performed; 0 to 2^CNT_W-1
- WR_DELAYS, 10, extra wait cycles before a write is performed; 0 to 2^CNT_W-1
- CNT_W, 16, width of the wait-state counter
- wb_clk_i  in  1  the single clock; everything is rising-edge
- wb_rst_n  in  1  reset, asynchronous and active-low
- wbs_cyc_i  in  1  bus cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  1 = write, 0 = read
- wbs_sel_i  in  DW/8  byte-lane enables, applied to writes only
- wbs_adr_i  in  32  byte address; bits [log2(DW/8)-1:0] are ignored
- wbs_dat_i  in  DW  write data
- wbs_ack_o  out  1  registered one-cycle acknowledge
- wbs_err_o  out  1  registered one-cycle error, for out-of-window accesses
- wbs_dat_o  out  DW  registered read data
- busy_o  out  1  high whenever the FSM is not in IDLE
- txn_cnt_o  out  16  count of completed (acked) transactions; wraps at 16'hFFFF

## Operation
- valid = wbs_cyc_i & wbs_stb_i.
- In-window test: wbs_adr_i[31:DEPTH_LOG2+log2(DW/8)] equals the same bits of BASE_ADDR.
- Word index = wbs_adr_i[DEPTH_LOG2+log2(DW/8)-1 : log2(DW/8)].
- FSM states: IDLE, WAIT, ACK, ERR.
- IDLE:
  - valid and in-window: latch we, sel, word index and write data; load the counter with WR_DELAYS if writing, else RD_DELAYS; go to WAIT.
  - valid and out-of-window: go to ERR.
  - otherwise stay in IDLE.
- WAIT:
  - wbs_cyc_i low: abort to IDLE. No memory write, no ack, counter unchanged.
  - else if counter == 0: perform the access, then go to ACK.
    - Write: update only the byte lanes whose latched sel bit is 1. sel == 0 still completes normally.
    - Read: register mem[index] into wbs_dat_o.
  - else decrement the counter and stay in WAIT.
- ACK: wbs_ack_o = 1; increment txn_cnt_o; return to IDLE.
- ERR: wbs_err_o = 1 with no memory effect; txn_cnt_o unchanged; return to IDLE.
- wbs_dat_o holds read data only during a read's ACK cycle; it is 0 in every other cycle, including write acks.
- The latched request is used for the whole transaction. Input changes during WAIT are ignored, except wbs_cyc_i, which is used for abort.
- RAM contents are not initialised and are not cleared by reset.

## Timing
- Reset (asynchronous assert, synchronous deassert by the system):
  - state = IDLE, counter = 0, latched request registers = 0
  - wbs_ack_o = 0, wbs_err_o = 0, wbs_dat_o = 0, busy_o = 0, txn_cnt_o = 0
- Reset asserted mid-transaction: return to IDLE immediately. Any pending write is dropped and no ack is issued.
- Latency: call the first cycle in which valid is sampled in IDLE cycle 0.
  - In-window: WAIT occupies cycles 1..D+1 and ack is high in cycle D+2, where D = RD_DELAYS or WR_DELAYS.
  - D = 0 gives ack in cycle 2.
  - Out-of-window: err is high in cycle 1.
- Ack and err are each exactly one cycle and never overlap.
- A request is recognised only in IDLE. If valid is still high in the cycle after ACK, it is treated as a new transaction.
- Read-after-write to the same word returns the new data, because the write completes before ACK.
- busy_o is high for the whole of WAIT, ACK and ERR.

## Test plan
- Read latency: DW=32, RD_DELAYS=10, WR_DELAYS=3. Write 32'hDEADBEEF to BASE+0x10 -> ack in cycle 5. Read BASE+0x10 -> ack in cycle 12 with wbs_dat_o = 32'hDEADBEEF; wbs_dat_o = 0 in the cycles before and after the ack.
- Byte lanes: write 32'h11223344 with sel=4'hF, then 32'hAABBCCDD with sel=4'b0101 -> read returns 32'h11BB33DD. A write with sel=0 leaves the word unchanged and is still acked.
- Out-of-window: read 32'h3000_0000 -> wbs_err_o high in cycle 1, no ack, txn_cnt_o unchanged, RAM unchanged.
- Abort: write 32'h5 to BASE, then start a write of 32'h9 to BASE and drop wbs_cyc_i in cycle 2 -> no ack, busy_o low in cycle 3, a later read returns 32'h5.
- Reset mid-WAIT: assert wb_rst_n low during WAIT -> all outputs 0 in the same cycle, no ack after release. txn_cnt_o wraps to 0 after 65536 acks.
- Zero delay and parameters: RD_DELAYS=WR_DELAYS=0 with DW=64, DEPTH_LOG2=4 -> ack in cycle 2. Back-to-back accesses to word 15 and word 0 are correct, and address bits [2:0] are ignored.
